iceboard_uart_mc: RTL and testbench

Parametrised multi-channel half-duplex UART engine for iceboard links. It replaces the single-channel iceboard control path with NUM_CH independent channels. Each channel has a TX serializer with RS-485 style driver-enable and guard time, an RX deserializer with echo suppression, and a per-channel RX FIFO. It sits between the system fabric (valid/ready streams) and the FPGA pins that go to the ice boards.

---
 rtl/iceboard_uart_pkg.sv | 34 +++
 rtl/iceboard_uart_mc_if.sv | 28 ++
 rtl/iceboard_uart_ch.sv | 254 +++++++++++++++++++++++++
 rtl/iceboard_uart_mc.sv | 53 +++++
 tb/tb_iceboard_uart_mc.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iceboard_uart_pkg.sv
// Shared types and helpers for the multi-channel iceboard UART.
// ICEBOARD_UART_PARITY_EN adds an even-parity state to both frame FSMs.
package iceboard_uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef ICEBOARD_UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP,
    TX_GUARD
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef ICEBOARD_UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Width of a counter that must hold indices 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iceboard_uart_mc_if.sv
// Fabric-side streams and board-side pins of all channels, packed per channel.
interface iceboard_uart_mc_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  logic [NUM_CH*DATA_W-1:0] tx_data;
  logic [NUM_CH-1:0]        tx_valid;
  logic [NUM_CH-1:0]        tx_ready;
  logic [NUM_CH*DATA_W-1:0] rx_data;
  logic [NUM_CH-1:0]        rx_valid;
  logic [NUM_CH-1:0]        rx_ready;
  logic [NUM_CH-1:0]        uart_rx;
  logic [NUM_CH-1:0]        uart_tx;
  logic [NUM_CH-1:0]        uart_de;
  logic [NUM_CH-1:0]        frame_err;
  logic [NUM_CH-1:0]        rx_overflow;
  logic [NUM_CH-1:0]        rx_overflow_clr;

  modport master (
    output tx_data, tx_valid, rx_ready, uart_rx, rx_overflow_clr,
    input  tx_ready, rx_data, rx_valid, uart_tx, uart_de, frame_err, rx_overflow
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, uart_rx, rx_overflow_clr,
    output tx_ready, rx_data, rx_valid, uart_tx, uart_de, frame_err, rx_overflow
  );
endinterface

// File: rtl/iceboard_uart_ch.sv
// One half-duplex UART channel: TX with driver-enable/guard, echo-suppressed RX, FWFT RX FIFO.
// ICEBOARD_UART_PARITY_EN inserts/checks an even-parity bit after the data bits.
module iceboard_uart_ch
  import iceboard_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int GUARD_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic              uart_rx_i,
  output logic              uart_tx_o,
  output logic              uart_de_o,
  output logic              frame_err_o,
  output logic              rx_overflow_o,
  input  logic              rx_overflow_clr_i
);
  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W = cnt_width((DATA_W > GUARD_BITS) ? DATA_W : GUARD_BITS);
  localparam int AW    = cnt_width(FIFO_DEPTH);

  tx_state_t tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic tx_line, tx_busy, tx_tick;

  rx_state_t rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [1:0] sync_q;
  logic rx_line, rx_tick, push, ferr_d, ferr_q;

`ifdef ICEBOARD_UART_PARITY_EN
  logic tx_par_q, tx_par_d, rx_perr_q, rx_perr_d;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic empty, full, pop, wr_en, ovf_set, ovf_q;

  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_tick = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign rx_line = sync_q[1];
  assign rx_tick = (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      sync_q     <= 2'b11;
      ferr_q     <= 1'b0;
`ifdef ICEBOARD_UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      sync_q     <= {sync_q[0], uart_rx_i};
      ferr_q     <= ferr_d;
`ifdef ICEBOARD_UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line    = 1'b1;
`ifdef ICEBOARD_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_busy) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
    case (tx_state_q)
      TX_IDLE: if (tx_valid_i) begin
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_sh_d    = tx_data_i;
`ifdef ICEBOARD_UART_PARITY_EN
        tx_par_d   = ^tx_data_i;
`endif
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_sh_q[0];
        if (tx_tick) begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + BIT_W'(1);
          if (tx_bit_q == BIT_W'(DATA_W - 1)) begin
            tx_bit_d = '0;
`ifdef ICEBOARD_UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef ICEBOARD_UART_PARITY_EN
      TX_PARITY: begin
        tx_line = tx_par_q;
        if (tx_tick) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tx_tick) tx_state_d = (GUARD_BITS == 0) ? TX_IDLE : TX_GUARD;
      TX_GUARD: if (tx_tick) begin
        tx_bit_d = tx_bit_q + BIT_W'(1);
        if (tx_bit_q == BIT_W'(GUARD_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Any activity of our own driver aborts reception: the line is carrying our echo.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    push       = 1'b0;
    ferr_d     = 1'b0;
`ifdef ICEBOARD_UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_HIGH) rx_cnt_d = rx_cnt_q + CNT_W'(1);
    case (rx_state_q)
      RX_IDLE: if (!rx_line && !tx_busy) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: begin
        if (tx_busy) rx_state_d = RX_WAIT_HIGH;
        else if (rx_cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tx_busy) rx_state_d = RX_WAIT_HIGH;
        else if (rx_tick) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_line, rx_sh_q[DATA_W-1:1]};
          rx_bit_d = rx_bit_q + BIT_W'(1);
          if (rx_bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef ICEBOARD_UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef ICEBOARD_UART_PARITY_EN
      RX_PARITY: begin
        if (tx_busy) rx_state_d = RX_WAIT_HIGH;
        else if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_line ^ (^rx_sh_q);
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (tx_busy) rx_state_d = RX_WAIT_HIGH;
        else if (rx_tick) begin
          rx_cnt_d = '0;
          if (!rx_line) begin
            ferr_d     = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end else begin
            rx_state_d = RX_IDLE;
`ifdef ICEBOARD_UART_PARITY_EN
            ferr_d = rx_perr_q;
            push   = !rx_perr_q;
`else
            push   = 1'b1;
`endif
          end
        end
      end
      RX_WAIT_HIGH: if (rx_line) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = rx_ready_i && !empty;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      ovf_q <= ovf_set || (ovf_q && !rx_overflow_clr_i);
    end
  end

  assign tx_ready_o    = !rst && !tx_busy;
  assign uart_tx_o     = rst || tx_line;
  assign uart_de_o     = !rst && tx_busy;
  assign rx_valid_o    = !rst && !empty;
  assign rx_data_o     = mem[rd_q];
  assign frame_err_o   = !rst && ferr_q;
  assign rx_overflow_o = !rst && ovf_q;

endmodule

// File: rtl/iceboard_uart_mc.sv
// NUM_CH independent iceboard UART channels sliced out of the packed interface buses.
// Parity is enabled per build with ICEBOARD_UART_PARITY_EN.
module iceboard_uart_mc
  import iceboard_uart_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int GUARD_BITS   = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  iceboard_uart_mc_if.slave bus
);
  logic [NUM_CH*DATA_W-1:0] rx_data_w;
  logic [NUM_CH-1:0] tx_ready_w, rx_valid_w, uart_tx_w, uart_de_w, frame_err_w, rx_ovf_w;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      iceboard_uart_ch #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .GUARD_BITS  (GUARD_BITS)
      ) u_ch (
        .clk              (clk_clk),
        .rst              (reset_reset),
        .tx_data_i        (bus.tx_data[gi*DATA_W +: DATA_W]),
        .tx_valid_i       (bus.tx_valid[gi]),
        .tx_ready_o       (tx_ready_w[gi]),
        .rx_data_o        (rx_data_w[gi*DATA_W +: DATA_W]),
        .rx_valid_o       (rx_valid_w[gi]),
        .rx_ready_i       (bus.rx_ready[gi]),
        .uart_rx_i        (bus.uart_rx[gi]),
        .uart_tx_o        (uart_tx_w[gi]),
        .uart_de_o        (uart_de_w[gi]),
        .frame_err_o      (frame_err_w[gi]),
        .rx_overflow_o    (rx_ovf_w[gi]),
        .rx_overflow_clr_i(bus.rx_overflow_clr[gi])
      );
    end
  endgenerate

  assign bus.tx_ready    = tx_ready_w;
  assign bus.rx_data     = rx_data_w;
  assign bus.rx_valid    = rx_valid_w;
  assign bus.uart_tx     = uart_tx_w;
  assign bus.uart_de     = uart_de_w;
  assign bus.frame_err   = frame_err_w;
  assign bus.rx_overflow = rx_ovf_w;

endmodule

// File: tb/tb_iceboard_uart_mc.sv
// Randomised self-checking bench for iceboard_uart_mc against a frame-level reference model.
module tb_iceboard_uart_mc;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CPB = 8;
  localparam int GB  = 1;
  localparam int DEP = 16;
`ifdef ICEBOARD_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] rx_drv = '1;
  logic [NCH-1:0] loop_mask = '0;
  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt [NCH];
  logic [7:0] exp_q [NCH][$];
  logic [NCH-1:0] exp_ovf = '0;

  iceboard_uart_mc_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  iceboard_uart_mc #(
    .NUM_CH(NCH), .DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .GUARD_BITS(GB)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.uart_rx = (loop_mask & bus.uart_tx) | (~loop_mask & rx_drv);

  initial for (int c = 0; c < NCH; c++) ferr_cnt[c] = 0;
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (bus.frame_err[c] === 1'b1) ferr_cnt[c] <= ferr_cnt[c] + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Transmit one byte and compare the line against the ideal frame shape.
  task automatic tx_frame(input int c, input logic [7:0] d, output logic [15:0] seen);
    int nb, total, de_n, busy_n;
    logic [15:0] exp_bits;
    logic [NCH-1:0] others;
    nb = DW + 2 + PAR;
    total = nb + GB;
    exp_bits = 16'(d) << 1;
    if (PAR == 1) exp_bits[9] = ^d;
    for (int i = nb - 1; i < total; i++) exp_bits[i] = 1'b1;
    seen = '0; de_n = 0; busy_n = 0; others = '1;
    @(negedge clk);
    check("tx_ready_before", 32'(bus.tx_ready[c]), 32'd1);
    bus.tx_data[c*DW +: DW] = d;
    bus.tx_valid[c] = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid[c] = 1'b0;
    for (int k = 0; k < total * CPB + 4; k++) begin
      @(negedge clk);
      if (k % CPB == CPB / 2 && k / CPB < total) seen[k/CPB] = bus.uart_tx[c];
      if (bus.uart_de[c]) de_n++;
      if (!bus.tx_ready[c]) busy_n++;
      others &= (bus.uart_tx | (NCH'(1) << c));
    end
    $display("tx ch%0d data=%02h line=%04h", c, d, seen);
    check("tx_frame_bits", 32'(seen), 32'(exp_bits));
    check("tx_de_cycles", 32'(de_n), 32'(total * CPB));
    check("tx_busy_cycles", 32'(busy_n), 32'(total * CPB));
    check("tx_others_idle", 32'(others), 32'hF);
  endtask

  task automatic drive_bits(input int c, input logic [7:0] d, input logic stop, input logic par_flip);
    @(negedge clk);
    rx_drv[c] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_drv[c] = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR == 1) begin
      rx_drv[c] = (^d) ^ par_flip;
      repeat (CPB) @(negedge clk);
    end
    rx_drv[c] = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic model_push(input int c, input logic [7:0] d);
    if (exp_q[c].size() == DEP) exp_ovf[c] = 1'b1;
    else exp_q[c].push_back(d);
  endtask

  task automatic send_rx(input int c, input logic [7:0] d);
    drive_bits(c, d, 1'b1, 1'b0);
    rx_drv[c] = 1'b1;
    repeat (3) @(negedge clk);
    model_push(c, d);
    $display("rx ch%0d frame=%02h queued=%0d", c, d, exp_q[c].size());
  endtask

  task automatic pop_check(input int c);
    logic [7:0] e;
    e = exp_q[c].pop_front();
    @(negedge clk);
    check("rx_valid", 32'(bus.rx_valid[c]), 32'd1);
    check("rx_data", 32'(bus.rx_data[c*DW +: DW]), 32'(e));
    $display("pop ch%0d data=%02h expected=%02h", c, bus.rx_data[c*DW +: DW], e);
    bus.rx_ready[c] = 1'b1;
    @(negedge clk);
    bus.rx_ready[c] = 1'b0;
  endtask

  task automatic drain(input int c);
    while (exp_q[c].size() > 0) pop_check(c);
    @(negedge clk);
    check("rx_empty_after_drain", 32'(bus.rx_valid[c]), 32'd0);
  endtask

  initial begin
    logic [15:0] seen;
    int f0, ch;
    logic [7:0] d;
    bus.tx_data = '0;
    bus.tx_valid = '0;
    bus.rx_ready = '0;
    bus.rx_overflow_clr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(bus.uart_tx), 32'hF);
    check("rst_uart_de", 32'(bus.uart_de), 32'h0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_overflow", 32'(bus.rx_overflow), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", 32'(bus.tx_ready), 32'hF);

    // TX frames: fixed first vector, then random channels and bytes
    tx_frame(0, 8'hA5, seen);
    for (int n = 0; n < 5; n++) tx_frame(int'($urandom_range(0, NCH - 1)), 8'($urandom), seen);

    // Single RX frame held in the FIFO until popped
    send_rx(2, 8'h3C);
    check("rx_other_valid", 32'(bus.rx_valid & 4'b1011), 32'h0);
    pop_check(2);
    check("rx_valid_after_pop", 32'(bus.rx_valid[2]), 32'd0);

    // Overflow on ch1 with random traffic on the other channels
    for (int i = 0; i <= DEP; i++) begin
      send_rx(1, 8'(i));
      if ($urandom_range(0, 2) == 0) begin
        ch = int'($urandom_range(0, 2));
        if (ch > 0) ch = ch + 1;
        send_rx(ch, 8'($urandom));
      end
    end
    @(negedge clk);
    check("overflow_flags", 32'(bus.rx_overflow), 32'(exp_ovf));
    for (int c = 0; c < NCH; c++) drain(c);
    check("overflow_held", 32'(bus.rx_overflow), 32'(exp_ovf));
    bus.rx_overflow_clr = '1;
    @(negedge clk);
    bus.rx_overflow_clr = '0;
    exp_ovf = '0;
    check("overflow_cleared", 32'(bus.rx_overflow), 32'(exp_ovf));

    // Bad stop bit followed by a long break: one error, nothing pushed
    f0 = ferr_cnt[0];
    d = 8'($urandom);
    drive_bits(0, d, 1'b0, 1'b0);
    repeat (30 * CPB) @(negedge clk);
    check("break_ferr_count", 32'(ferr_cnt[0] - f0), 32'd1);
    check("break_no_push", 32'(bus.rx_valid[0]), 32'd0);
    rx_drv[0] = 1'b1;
    repeat (CPB) @(negedge clk);
    check("break_ferr_after_high", 32'(ferr_cnt[0] - f0), 32'd1);
    send_rx(0, 8'($urandom));
    drain(0);

    // Short glitch on ch3 is not a start bit
    f0 = ferr_cnt[3];
    @(negedge clk);
    rx_drv[3] = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv[3] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_ferr", 32'(ferr_cnt[3] - f0), 32'd0);
    check("glitch_no_push", 32'(bus.rx_valid[3]), 32'd0);

    // Own transmission looped back into the receiver is ignored
    f0 = ferr_cnt[2];
    loop_mask[2] = 1'b1;
    tx_frame(2, 8'h55, seen);
    repeat (2 * CPB) @(negedge clk);
    check("loopback_no_push", 32'(bus.rx_valid[2]), 32'd0);
    check("loopback_no_ferr", 32'(ferr_cnt[2] - f0), 32'd0);
    loop_mask[2] = 1'b0;

`ifdef ICEBOARD_UART_PARITY_EN
    tx_frame(1, 8'h07, seen);
    check("tx_parity_bit", 32'(seen[9]), 32'd1);
    f0 = ferr_cnt[1];
    drive_bits(1, 8'h07, 1'b1, 1'b1);
    rx_drv[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("parity_ferr", 32'(ferr_cnt[1] - f0), 32'd1);
    check("parity_no_push", 32'(bus.rx_valid[1]), 32'd0);
    send_rx(1, 8'h07);
    drain(1);
`endif

    // Reset in the middle of a frame
    @(negedge clk);
    bus.tx_data[0 +: DW] = 8'hF0;
    bus.tx_valid[0] = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid[0] = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uart_tx", 32'(bus.uart_tx), 32'hF);
    check("midrst_uart_de", 32'(bus.uart_de), 32'h0);
    check("midrst_tx_ready", 32'(bus.tx_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", 32'(bus.tx_ready), 32'hF);
    check("midrst_release_de", 32'(bus.uart_de), 32'h0);
    tx_frame(0, 8'($urandom), seen);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end
endmodule
